// File: rtl/quad_gen.sv
// Quadrature waveform generator: turns cw/ccw detent requests into four-phase
// A/B Gray sequences and keeps a signed running detent count.
module quad_gen #(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned POS_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_valid,
    input  logic                    step_dir,
    output logic                    step_ready,
    output logic                    a,
    output logic                    b,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
);

    localparam int unsigned TMR_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        P4
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             dir;
    logic             hold_valid;
    logic             hold_dir;

    logic expire_c;
    logic exit_c;
    logic accept_c;

    assign expire_c   = (timer == TMR_LAST);
    assign exit_c     = (state == P4) && expire_c;
    assign accept_c   = step_valid && !hold_valid;
    assign step_ready = !hold_valid;

    // {a,b} for a phase; P1 and P3 mirror each other between directions
    function automatic logic [1:0] phase_ab(input state_t s, input logic cw);
        case (s)
            P1:      phase_ab = cw ? 2'b01 : 2'b10;
            P2:      phase_ab = 2'b11;
            P3:      phase_ab = cw ? 2'b10 : 2'b01;
            default: phase_ab = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            dir        <= 1'b0;
            hold_valid <= 1'b0;
            hold_dir   <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                timer <= '0;
                // hold register is always empty here, so a request is taken directly
                if (step_valid) begin
                    state    <= P1;
                    dir      <= step_dir;
                    {a, b}   <= phase_ab(P1, step_dir);
                    busy     <= 1'b1;
                end
            end else if (expire_c) begin
                timer <= '0;
                case (state)
                    P1: begin
                        state  <= P2;
                        {a, b} <= phase_ab(P2, dir);
                    end
                    P2: begin
                        state  <= P3;
                        {a, b} <= phase_ab(P3, dir);
                    end
                    P3: begin
                        state  <= P4;
                        {a, b} <= phase_ab(P4, dir);
                    end
                    default: begin
                        done     <= 1'b1;
                        position <= dir ? position + POS_W'(1) : position - POS_W'(1);
                        // chain the next detent on the same edge so there is no idle gap
                        if (hold_valid) begin
                            state      <= P1;
                            dir        <= hold_dir;
                            {a, b}     <= phase_ab(P1, hold_dir);
                            hold_valid <= 1'b0;
                        end else if (step_valid) begin
                            state  <= P1;
                            dir    <= step_dir;
                            {a, b} <= phase_ab(P1, step_dir);
                        end else begin
                            state  <= IDLE;
                            {a, b} <= 2'b00;
                            busy   <= 1'b0;
                        end
                    end
                endcase
            end else begin
                timer <= timer + TMR_W'(1);
            end

            // mid-detent requests park in the one-entry hold register
            if ((state != IDLE) && !exit_c && accept_c) begin
                hold_valid <= 1'b1;
                hold_dir   <= step_dir;
            end
        end
    end

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: three instances (PHASE_CYCLES 4/2/1), a detent-level
// reference model checked every cycle, plus literal spot checks.
module tb_quad_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic sv  [3];
    logic sd  [3];
    logic rdy [3];
    logic ao  [3];
    logic bo  [3];
    logic bsy [3];
    logic dn  [3];
    logic [15:0] pos0;
    logic [15:0] pos1;
    logic [3:0]  pos2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    quad_gen #(.PHASE_CYCLES(4), .POS_W(16)) u_pc4 (
        .clk(clk), .reset(rst[0]), .step_valid(sv[0]), .step_dir(sd[0]),
        .step_ready(rdy[0]), .a(ao[0]), .b(bo[0]), .busy(bsy[0]), .done(dn[0]),
        .position(pos0));

    quad_gen #(.PHASE_CYCLES(2), .POS_W(16)) u_pc2 (
        .clk(clk), .reset(rst[1]), .step_valid(sv[1]), .step_dir(sd[1]),
        .step_ready(rdy[1]), .a(ao[1]), .b(bo[1]), .busy(bsy[1]), .done(dn[1]),
        .position(pos1));

    quad_gen #(.PHASE_CYCLES(1), .POS_W(4)) u_pc1 (
        .clk(clk), .reset(rst[2]), .step_valid(sv[2]), .step_dir(sd[2]),
        .step_ready(rdy[2]), .a(ao[2]), .b(bo[2]), .busy(bsy[2]), .done(dn[2]),
        .position(pos2));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", nm, got, req, cyc);
        end
    endtask

    // detent-level model: active detent, elapsed clocks, one pending request, count
    int pc_of [3] = '{4, 2, 1};
    int pmask [3] = '{32'hFFFF, 32'hFFFF, 32'hF};
    bit m_active [3];
    bit m_dir    [3];
    bit m_pend   [3];
    bit m_pdir   [3];
    bit m_done   [3];
    bit m_acc    [3];
    int m_el     [3];
    int m_pos    [3];

    task automatic model_clear(input int k);
        m_active[k] = 0; m_dir[k] = 0; m_pend[k] = 0; m_pdir[k] = 0;
        m_done[k] = 0; m_acc[k] = 0; m_el[k] = 0; m_pos[k] = 0;
    endtask

    task automatic model_start(input int k, input bit d);
        m_active[k] = 1;
        m_dir[k]    = d;
        m_el[k]     = 0;
    endtask

    task automatic model_step(input int k);
        m_done[k] = 0;
        m_acc[k]  = 0;
        if (rst[k]) begin
            model_clear(k);
        end else if (m_active[k]) begin
            m_el[k]++;
            if (m_el[k] == 4 * pc_of[k]) begin
                m_done[k]   = 1;
                m_pos[k]    = m_pos[k] + (m_dir[k] ? 1 : -1);
                m_active[k] = 0;
                if (m_pend[k]) begin
                    model_start(k, m_pdir[k]);
                    m_pend[k] = 0;
                end else if (sv[k]) begin
                    model_start(k, sd[k]);
                    m_acc[k] = 1;
                end
            end else if (sv[k] && !m_pend[k]) begin
                m_pend[k] = 1;
                m_pdir[k] = sd[k];
                m_acc[k]  = 1;
            end
        end else if (sv[k]) begin
            model_start(k, sd[k]);
            m_acc[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    function automatic logic [1:0] exp_ab(input int k);
        int ph;
        if (!m_active[k]) return 2'b00;
        ph = m_el[k] / pc_of[k];
        case (ph)
            0:       return m_dir[k] ? 2'b01 : 2'b10;
            1:       return 2'b11;
            2:       return m_dir[k] ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] dut_pos(input int k);
        case (k)
            0:       return {16'd0, pos0};
            1:       return {16'd0, pos1};
            default: return {28'd0, pos2};
        endcase
    endfunction

    int done_q1[$];
    int busy_cnt1 = 0;
    int rdy_low1  = 0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ab[%0d]", k), 32'({ao[k], bo[k]}), 32'(exp_ab(k)));
            check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_active[k]));
            check($sformatf("done[%0d]", k), 32'(dn[k]), 32'(m_done[k]));
            check($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(!m_pend[k]));
            check($sformatf("position[%0d]", k), dut_pos(k), 32'(m_pos[k]) & 32'(pmask[k]));
        end
        if (dn[1]) done_q1.push_back(cyc);
        if (bsy[1]) busy_cnt1++;
        if (!rdy[1]) rdy_low1++;
    end

    // loopback decoder on the PHASE_CYCLES=1 instance: one pulse per completed detent
    logic [1:0] dprev = 2'b00;
    int cw_cnt = 0;
    int ccw_cnt = 0;
    int order_bad = 0;
    always @(posedge clk) begin
        #1;
        if ({ao[2], bo[2]} != dprev) begin
            check("one_bit_change", 32'($countones({ao[2], bo[2]} ^ dprev)), 32'd1);
            if ({ao[2], bo[2]} == 2'b00) begin
                if (dprev == 2'b10) begin
                    cw_cnt++;
                    if (ccw_cnt > 0) order_bad++;
                end else if (dprev == 2'b01) begin
                    ccw_cnt++;
                end
            end
            dprev = {ao[2], bo[2]};
        end
    end

    task automatic run_reqs(input int k, input logic [31:0] dirs, input int n, output int t_first);
        int i = 0;
        int g = 0;
        t_first = -1;
        @(negedge clk);
        while (i < n && g < 1000) begin
            sv[k] = 1'b1;
            sd[k] = dirs[i];
            @(negedge clk);
            g++;
            if (m_acc[k]) begin
                if (i == 0) t_first = cyc;
                i++;
            end
        end
        sv[k] = 1'b0;
        check("requests_accepted", 32'(i), 32'(n));
        g = 0;
        while ((m_active[k] || m_pend[k]) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", 32'(g < 1000), 32'd1);
        @(negedge clk);
    endtask

    logic [1:0]  cap_ab   [20];
    logic        cap_done [20];
    logic        cap_busy [20];
    logic [31:0] cap_pos  [20];

    task automatic capture(input int k, input logic d, input int n);
        @(negedge clk);
        sv[k] = 1'b1;
        sd[k] = d;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) sv[k] = 1'b0;
            cap_ab[c]   = {ao[k], bo[k]};
            cap_done[c] = dn[k];
            cap_busy[c] = bsy[k];
            cap_pos[c]  = dut_pos(k);
        end
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        rst[k] = 1'b1;
        model_clear(k);
        @(negedge clk);
        rst[k] = 1'b0;
    endtask

    int t0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            sv[k]  = 1'b0;
            sd[k]  = 1'b0;
            model_clear(k);
        end
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(rdy[0]), 32'd1);
        check("reset_ab", 32'({ao[1], bo[1]}), 32'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (2) @(negedge clk);

        // single cw detent, PHASE_CYCLES=4
        capture(0, 1'b1, 17);
        check("cw_ab_c0", 32'(cap_ab[0]), 32'h1);
        check("cw_ab_c3", 32'(cap_ab[3]), 32'h1);
        check("cw_ab_c4", 32'(cap_ab[4]), 32'h3);
        check("cw_ab_c7", 32'(cap_ab[7]), 32'h3);
        check("cw_ab_c8", 32'(cap_ab[8]), 32'h2);
        check("cw_ab_c11", 32'(cap_ab[11]), 32'h2);
        check("cw_ab_c12", 32'(cap_ab[12]), 32'h0);
        check("cw_busy_c15", 32'(cap_busy[15]), 32'd1);
        check("cw_done_c15", 32'(cap_done[15]), 32'd0);
        check("cw_pos_c15", cap_pos[15], 32'd0);
        check("cw_done_c16", 32'(cap_done[16]), 32'd1);
        check("cw_busy_c16", 32'(cap_busy[16]), 32'd0);
        check("cw_pos_c16", cap_pos[16], 32'd1);

        // single ccw detent, PHASE_CYCLES=2
        capture(1, 1'b0, 9);
        check("ccw_ab_c1", 32'(cap_ab[1]), 32'h2);
        check("ccw_ab_c2", 32'(cap_ab[2]), 32'h3);
        check("ccw_ab_c5", 32'(cap_ab[5]), 32'h1);
        check("ccw_ab_c6", 32'(cap_ab[6]), 32'h0);
        check("ccw_done_c7", 32'(cap_done[7]), 32'd0);
        check("ccw_done_c8", 32'(cap_done[8]), 32'd1);
        check("ccw_pos_c8", cap_pos[8], 32'hFFFF);

        // reset in cycle 5 of a cw detent with a request parked in the hold register
        pulse_reset(0);
        @(negedge clk);
        sv[0] = 1'b1;
        sd[0] = 1'b1;
        @(negedge clk);
        sd[0] = 1'b0;
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_ab", 32'({ao[0], bo[0]}), 32'h3);
        check("pre_rst_ready", 32'(rdy[0]), 32'd0);
        rst[0] = 1'b1;
        model_clear(0);
        #1;
        check("rst_ab", 32'({ao[0], bo[0]}), 32'h0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_pos", dut_pos(0), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(bsy[0]), 32'd0);

        // back-to-back cw, cw, ccw with valid held high, PHASE_CYCLES=2
        pulse_reset(1);
        done_q1.delete();
        busy_cnt1 = 0;
        rdy_low1  = 0;
        run_reqs(1, 32'b011, 3, t0);
        check("b2b_done_count", 32'(done_q1.size()), 32'd3);
        if (done_q1.size() == 3) begin
            check("b2b_done0", 32'(done_q1[0] - t0), 32'd8);
            check("b2b_done1", 32'(done_q1[1] - t0), 32'd16);
            check("b2b_done2", 32'(done_q1[2] - t0), 32'd24);
        end
        check("b2b_busy_cycles", 32'(busy_cnt1), 32'd24);
        check("b2b_ready_low_cycles", 32'(rdy_low1), 32'd14);
        check("b2b_pos", dut_pos(1), 32'd1);

        // loopback into a decoder, PHASE_CYCLES=1: 5 cw then 3 ccw
        cw_cnt = 0;
        ccw_cnt = 0;
        order_bad = 0;
        run_reqs(2, 32'h1F, 8, t0);
        check("loop_cw", 32'(cw_cnt), 32'd5);
        check("loop_ccw", 32'(ccw_cnt), 32'd3);
        check("loop_order", 32'(order_bad), 32'd0);
        check("loop_pos", dut_pos(2), 32'd2);

        // wrap with POS_W=4
        pulse_reset(2);
        run_reqs(2, 32'h7F, 7, t0);
        check("wrap_pos7", dut_pos(2), 32'h7);
        run_reqs(2, 32'h1, 1, t0);
        check("wrap_pos_m8", dut_pos(2), 32'h8);
        run_reqs(2, 32'h0, 1, t0);
        check("wrap_back_7", dut_pos(2), 32'h7);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_gen.md
# quad_gen

Quadrature waveform generator: the transmit-side counterpart of the single-cycle quadrature decoder. It accepts detent requests (one step, clockwise or counter-clockwise) over a valid/ready handshake and drives a full four-phase A/B Gray sequence per detent on `a`/`b`. It also keeps a signed running position count. It is used to emulate a rotary encoder for loopback testing and for board-level stimulus of the decoder path.

## Interface
- `PHASE_CYCLES`, default 4: clocks each A/B phase is held; legal range ≥1.
- `POS_W`, default 16: width of the signed position counter.
- `clk`, input, 1: single clock; all logic on posedge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `step_valid`, input, 1: detent request present.
- `step_dir`, input, 1: 1 = clockwise (cw), 0 = counter-clockwise (ccw); qualified by `step_valid`.
- `step_ready`, output, 1: request accepted on an edge where `step_valid & step_ready`.
- `a`, output, 1: quadrature channel A, registered.
- `b`, output, 1: quadrature channel B, registered.
- `busy`, output, 1: engine is driving a detent (state ≠ IDLE).
- `done`, output, 1: one-cycle pulse when a detent completes.
- `position`, output, POS_W: signed two's-complement detent count.

## Operation
- Sequences, as {a,b}:
  - cw: 00→01→11→10→00.
  - ccw: 00→10→11→01→00.
  - These match the decoder's cw/ccw recognition.
- FSM states:
  - IDLE: {a,b}=00.
  - P1: 01 cw / 10 ccw.
  - P2: 11.
  - P3: 10 cw / 01 ccw.
  - P4: 00, settle.
- Phase timer counts 0..PHASE_CYCLES-1. On the edge where the timer = PHASE_CYCLES-1, the FSM advances P1→P2→P3→P4 and the timer clears.
- Request buffering:
  - One-entry hold register (valid bit + dir).
  - `step_ready` = !hold_valid.
  - In IDLE, an accepted request loads the engine directly. The hold register stays empty.
  - In P1..P4, an accepted request is written to the hold register.
- P4 exit, on the edge where the timer expires:
  - `done` goes to 1 for one cycle.
  - `position` updates: +1 for cw, −1 for ccw. It wraps modulo 2^POS_W with no saturation.
  - If hold_valid: go to P1 with the held dir and clear hold_valid.
  - Else, if `step_valid` is high: accept it directly and go to P1. This is legal because `step_ready`=1 when the hold register is empty.
  - Else: go to IDLE.
- Direction is latched per detent. `step_dir` changes during a detent do not affect it.
- Reverse-direction requests are allowed back-to-back. Each detent always completes all four phases.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values (asynchronous, immediate): `a`=0, `b`=0, `done`=0, `busy`=0, `position`=0, `step_ready`=1. FSM goes to IDLE, timer=0, hold cleared.
- Reset mid-detent aborts it: outputs return to 00 and `position` is not updated.
- Accepting edge T from IDLE: {a,b}=P1 value is visible from T, and `busy`=1 from T.
- A single detent occupies exactly 4·PHASE_CYCLES clocks:
  - P1 visible over [T, T+PHASE_CYCLES).
  - P4 ends at edge T+4·PHASE_CYCLES.
  - At that edge: `done`=1 and `position` updates. Then {a,b}=00 and the FSM returns to IDLE (or starts the next detent).
- Back-to-back detents: the next P1 starts on the same edge as `done`. No idle cycle; the period is exactly 4·PHASE_CYCLES.
- Exactly one of `a`/`b` changes per transition. There are no glitches because both are registered.
- With PHASE_CYCLES=1, one transition occurs per clock. This is still decodable by a same-clock decoder that samples every edge.
- `step_ready` falls the cycle after the hold register is written. It rises the cycle after the hold register is consumed.

## Test plan
- Single cw, PHASE_CYCLES=4, request accepted at edge 0 -> {a,b}=01 over cycles 0–3, 11 over 4–7, 10 over 8–11, 00 over 12–15; `done` pulses at edge 16; `position`=1; `busy` low after 16.
- Single ccw, PHASE_CYCLES=2 -> sequence 10,11,01,00, each held 2 cycles; `done` at edge 8; `position`=−1 (0xFFFF).
- Three back-to-back requests cw, cw, ccw with `step_valid` held high -> `step_ready` low while the hold register is full; 24 contiguous cycles with no IDLE gap (PHASE_CYCLES=2); three `done` pulses at edges 8, 16, 24; final `position`=1.
- Wrap, POS_W=4, preload via 7 cw detents then 1 more cw -> `position` goes 7→−8 (4'b1000); symmetric −8 then ccw → 7.
- Assert `reset` at cycle 5 of a cw detent (PHASE_CYCLES=4) -> immediately {a,b}=00, `busy`=0, `done`=0, `position` unchanged at its pre-detent value, hold cleared, `step_ready`=1.
- Loopback into the decoder, PHASE_CYCLES=1, 5 cw then 3 ccw -> exactly 5 `cw_out` pulses then 3 `ccw_out` pulses; `position`=2.
